// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with flush/stall handling and optional BTB (macro PC_GEN_BTB_EN)
module pc_gen #(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  PC_STEP     = 4,
  parameter int                  BTB_ENTRIES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_en,
  input  logic                if_stall,
  input  logic                if_flush,
  input  logic [PC_WIDTH-1:0] flush_pc,
  input  logic                bp_upd_en,
  input  logic [PC_WIDTH-1:0] bp_upd_pc,
  input  logic [PC_WIDTH-1:0] bp_upd_target,
  input  logic                bp_upd_taken,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_valid,
  output logic                pc_pred_taken
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                r_pc_valid, w_pc_valid_nxt;
  logic [PC_WIDTH-1:0] r_pend_pc, w_pend_pc_nxt;
  logic                r_pend_vld, w_pend_vld_nxt;
  logic                w_btb_hit;
  logic [PC_WIDTH-1:0] w_btb_target;

`ifdef PC_GEN_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] r_btb_vld;
  logic [TAG_W-1:0]       r_btb_tag [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    r_btb_tgt [BTB_ENTRIES];
  logic [IDX_W-1:0]       w_rd_idx;
  logic [IDX_W-1:0]       w_wr_idx;
  logic                   w_unused_lo;

  // Byte offset bits never take part in indexing or tagging.
  assign w_unused_lo  = ^bp_upd_pc[1:0];
  assign w_rd_idx     = r_pc[IDX_W+1:2];
  assign w_wr_idx     = bp_upd_pc[IDX_W+1:2];
  // Lookup reads registered state, so a same-edge update is seen only next cycle.
  assign w_btb_hit    = r_pc_valid & r_btb_vld[w_rd_idx] &
                        (r_btb_tag[w_rd_idx] == r_pc[PC_WIDTH-1:IDX_W+2]);
  assign w_btb_target = r_btb_tgt[w_rd_idx];

  // Valid bits: install on taken update, invalidate the indexed entry otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_vld <= '0;
    end else if (bp_upd_en) begin
      r_btb_vld[w_wr_idx] <= bp_upd_taken;
    end
  end

  // Tag/target payload needs no reset; it is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (bp_upd_en && bp_upd_taken) begin
      r_btb_tag[w_wr_idx] <= bp_upd_pc[PC_WIDTH-1:IDX_W+2];
      r_btb_tgt[w_wr_idx] <= bp_upd_target;
    end
  end
`else
  logic w_unused_bp;

  // Update port kept for interface compatibility; nothing consumes it.
  assign w_unused_bp  = ^{bp_upd_en, bp_upd_pc, bp_upd_target, bp_upd_taken, BTB_ENTRIES[0]};
  assign w_btb_hit    = 1'b0;
  assign w_btb_target = '0;
`endif

  // State, fetch PC and pending-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_pend_pc  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pc_valid <= w_pc_valid_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_pend_vld <= w_pend_vld_nxt;
    end
  end

  // Next-state and next-pc selection: flush > stall > prediction > sequential.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pc_valid_nxt = r_pc_valid;
    w_pend_pc_nxt  = r_pend_pc;
    w_pend_vld_nxt = r_pend_vld;
    if (!cpu_en) begin
      // Frozen: pc held, redirects parked until the core is enabled again.
      w_state_nxt    = S_IDLE;
      w_pc_valid_nxt = 1'b0;
      if (if_flush) begin
        w_pend_pc_nxt  = flush_pc;
        w_pend_vld_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // Wake-up edge presents the held or parked address without stepping.
          w_state_nxt    = S_RUN;
          w_pc_valid_nxt = 1'b1;
          w_pend_vld_nxt = 1'b0;
          if (if_flush) begin
            w_pc_nxt = flush_pc;
          end else if (r_pend_vld) begin
            w_pc_nxt = r_pend_pc;
          end
        end
        default: begin
          if (if_flush) begin
            w_pc_nxt       = flush_pc;
            w_pend_vld_nxt = 1'b0;
          end else if (if_stall) begin
            w_pc_nxt = r_pc;
          end else if (w_btb_hit) begin
            w_pc_nxt = w_btb_target;
          end else begin
            w_pc_nxt = r_pc + PC_WIDTH'(PC_STEP);
          end
        end
      endcase
    end
  end

  assign pc            = r_pc;
  assign pc_valid      = r_pc_valid;
  assign pc_pred_taken = w_btb_hit;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen (BTB checks under PC_GEN_BTB_EN)
module tb_pc_gen;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_en = 1'b0;
  logic         if_stall = 1'b0;
  logic         if_flush = 1'b0;
  logic [W-1:0] flush_pc = '0;
  logic         bp_upd_en = 1'b0;
  logic [W-1:0] bp_upd_pc = '0;
  logic [W-1:0] bp_upd_target = '0;
  logic         bp_upd_taken = 1'b0;
  logic [W-1:0] pc;
  logic         pc_valid;
  logic         pc_pred_taken;

  pc_gen #(.PC_WIDTH(W), .RESET_PC('0), .PC_STEP(4), .BTB_ENTRIES(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .if_stall(if_stall), .if_flush(if_flush),
    .flush_pc(flush_pc), .bp_upd_en(bp_upd_en), .bp_upd_pc(bp_upd_pc),
    .bp_upd_target(bp_upd_target), .bp_upd_taken(bp_upd_taken),
    .pc(pc), .pc_valid(pc_valid), .pc_pred_taken(pc_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] pc;
    logic         v;
    logic         p;
    logic [7:0]   tid;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] cur_tid = 8'd0;

  // Reference model: architectural fetch state plus a 4-entry branch table.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_pend_pc;
  bit           m_run;
  bit           m_pend;
  bit           m_bv[4];
  logic [W-1:0] m_bpc[4];
  logic [W-1:0] m_btgt[4];

  function automatic int slot_of(logic [W-1:0] a);
    return int'((a >> 2) % 4);
  endfunction

  function automatic bit m_hit(logic [W-1:0] a);
`ifdef PC_GEN_BTB_EN
    int i = slot_of(a);
    return m_bv[i] && ((m_bpc[i] >> 4) == (a >> 4));
`else
    return (a != a);
`endif
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.pc  = m_pc;
    e.v   = m_run;
    e.p   = m_run && m_hit(m_pc);
    e.tid = cur_tid;
    return e;
  endfunction

  task automatic m_reset();
    m_pc   = '0;
    m_run  = 0;
    m_pend = 0;
    m_pend_pc = '0;
    for (int i = 0; i < 4; i++) m_bv[i] = 0;
  endtask

  // Apply current inputs for one clock, advancing the model alongside.
  task automatic step();
    bit           pred;
    logic [W-1:0] tgt;
    pred = m_run && m_hit(m_pc);
    tgt  = m_btgt[slot_of(m_pc)];
    if (!cpu_en) begin
      m_run = 0;
      if (if_flush) begin
        m_pend = 1;
        m_pend_pc = flush_pc;
      end
    end else if (!m_run) begin
      if (if_flush) m_pc = flush_pc;
      else if (m_pend) m_pc = m_pend_pc;
      m_pend = 0;
      m_run  = 1;
    end else if (if_flush) begin
      m_pc = flush_pc;
      m_pend = 0;
    end else if (if_stall) begin
      m_pc = m_pc;
    end else if (pred) begin
      m_pc = tgt;
    end else begin
      m_pc = m_pc + 32'd4;
    end
`ifdef PC_GEN_BTB_EN
    if (bp_upd_en) begin
      m_bv[slot_of(bp_upd_pc)] = bp_upd_taken;
      if (bp_upd_taken) begin
        m_bpc[slot_of(bp_upd_pc)]  = bp_upd_pc;
        m_btgt[slot_of(bp_upd_pc)] = bp_upd_target;
      end
    end
`endif
    @(posedge clk);
    exp_q.push_back(m_out());
    #1;
  endtask

  // Reset asserted off-edge; the current cycle must already show reset values.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    m_reset();
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      exp_q.push_back(m_out());
    end
    repeat (n) begin
      @(posedge clk);
      exp_q.push_back(m_out());
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit en, input bit st, input bit fl, input logic [W-1:0] fpc);
    cpu_en   = en;
    if_stall = st;
    if_flush = fl;
    flush_pc = fpc;
    step();
  endtask

  task automatic bp(input bit en, input logic [W-1:0] a, input logic [W-1:0] t, input bit tk);
    bp_upd_en     = en;
    bp_upd_pc     = a;
    bp_upd_target = t;
    bp_upd_taken  = tk;
  endtask

  // Monitor: one expected entry per falling edge, compared against DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (pc !== e.pc || pc_valid !== e.v || pc_pred_taken !== e.p) begin
          n_bad++;
          $display("FAIL t%0d pc/valid/pred got %h/%b/%b want %h/%b/%b at %0t",
                   e.tid, pc, pc_valid, pc_pred_taken, e.pc, e.v, e.p, $time);
        end
      end
    end
  end

  initial begin
    m_reset();
    // T1: reset, enable after two idle cycles
    cur_tid = 8'd1;
    do_reset(2);
    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);
    repeat (4) drive(1, 0, 0, '0);
    // T2: run to 0x10 then stall three cycles
    cur_tid = 8'd2;
    drive(1, 0, 0, '0);
    repeat (3) drive(1, 1, 0, '0);
    repeat (2) drive(1, 0, 0, '0);
    // T3: flush beats stall
    cur_tid = 8'd3;
    drive(1, 1, 1, 32'h200);
    drive(1, 0, 0, '0);
    // T4: parked redirects while disabled, last one wins
    cur_tid = 8'd4;
    drive(0, 0, 1, 32'h80);
    drive(0, 0, 1, 32'h90);
    drive(0, 0, 0, '0);
    repeat (3) drive(1, 0, 0, '0);
    // T5: sequential wrap at the top of the address space
    cur_tid = 8'd5;
    drive(1, 0, 1, 32'hFFFF_FFFC);
    repeat (2) drive(1, 0, 0, '0);
`ifdef PC_GEN_BTB_EN
    // T6: install, predict, invalidate
    cur_tid = 8'd6;
    bp(1, 32'h20, 32'h100, 1);
    drive(1, 0, 0, '0);
    bp(0, '0, '0, 0);
    drive(1, 0, 1, 32'h20);
    repeat (3) drive(1, 0, 0, '0);
    bp(1, 32'h20, 32'h0, 0);
    drive(1, 0, 1, 32'h20);
    bp(0, '0, '0, 0);
    repeat (3) drive(1, 0, 0, '0);
`endif
    // Mid-operation reset drops a parked redirect
    cur_tid = 8'd7;
    drive(0, 0, 1, 32'h400);
    do_reset(1);
    repeat (3) drive(1, 0, 0, '0);
    // Randomized traffic
    cur_tid = 8'd8;
    for (int k = 0; k < 3000; k++) begin
      logic [W-1:0] fpc;
      if ($urandom_range(0, 7) == 0) fpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
      else fpc = 32'($urandom_range(0, 31)) * 4;
      bp(($urandom_range(0, 3) == 0), 32'($urandom_range(0, 23)) * 4,
         32'($urandom_range(0, 23)) * 4, ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 499) == 0) do_reset(1);
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0), fpc);
    end
    bp(0, '0, '0, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain queue got %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
